line_clear_engine: RTL and testbench
====================================

# line_clear_engine

Post-lock line-clear stage that sits directly downstream of the playfield memory's block-write path. After a piece is committed, it scans the playfield bottom-up through the memory's line read port. It removes every completely filled row and compacts the remaining rows downward through the memory's line write port. It reports the number of lines cleared and signals completion to the game controller.

## Interface
- `word_width_p`, default 10: playfield width in cells (bits per row).
- `size_p`, default 20: playfield height in rows. Row 0 is the top row; row `size_p-1` is the bottom row.

- `clk_i`, in, 1: clock.
- `reset_n_i`, in, 1: reset. One clock; reset is synchronous and active-low.
- `start_i`, in, 1: begin a clear pass. Sampled only while `ready_o`=1.
- `ready_o`, out, 1: engine idle, can accept `start_i`.
- `done_o`, out, 1: one-cycle pulse when the pass completes.
- `lines_cleared_o`, out, `$clog2(size_p+1)`: full rows removed by the last pass.
- `mem_ready_i`, in, 1: memory is idle (not servicing a 4×4 block write).
- `read_addr_o`, out, `$clog2(size_p)`: line read address.
- `read_data_i`, in, `word_width_p`: combinational read data for `read_addr_o`, valid in the same cycle.
- `write_addr_o`, out, `$clog2(size_p)`: line write address.
- `write_data_o`, out, `word_width_p`: line write data.
- `v_w_o`, out, 1: line write strobe. Memory commits the write on the next clock edge.
- `score_o`, out, 24: present only with `LINE_CLEAR_SCORE_EN` (see Configuration).

## Operation
- FSM states: eIDLE, eSCAN, eFILL, eDONE. Registers: `src_r` and `dst_r` (row pointers) and `cleared_r` (clear count).
- **eIDLE**
  - `ready_o`=1.
  - On `start_i`: `src_r` and `dst_r` are set to `size_p-1`, `cleared_r` is set to 0, next state is eSCAN.
  - `start_i` is ignored in every other state.
- **eSCAN**, one row per unstalled cycle, with `read_addr_o`=`src_r`:
  - If `read_data_i` is all ones: `cleared_r`++, `src_r`--, no write.
  - Otherwise: if `src_r`≠`dst_r`, assert `v_w_o` with `write_addr_o`=`dst_r` and `write_data_o`=`read_data_i`. Then `src_r`-- and `dst_r`--.
  - When `src_r`=0 is processed: next state is eFILL if `cleared_r` (including this row) >0, else eDONE.
- **eFILL**
  - Assert `v_w_o` with `write_addr_o`=`dst_r` and `write_data_o`=0, then `dst_r`--.
  - After writing row 0, next state is eDONE.
  - Fill writes = `cleared_r`.
- **eDONE**
  - `done_o`=1 and `lines_cleared_o`<=`cleared_r`, then eIDLE.
  - `lines_cleared_o` holds its value until the next eDONE.
- **Stall:** in eSCAN and eFILL, if `mem_ready_i`=0, no register updates and `v_w_o`=0. The state and pointers hold.
- **No full rows:** `src_r`=`dst_r` throughout, so zero writes are issued.
- **All rows full:** `cleared_r`=`size_p` and every row is zero-filled in eFILL.
- **Reset mid-pass:** return to eIDLE and zero all registers. Rows already written stay written; no rollback.

## Timing
- Reset values: `ready_o`=1; `done_o`, `v_w_o`, `lines_cleared_o`, `read_addr_o`, `write_addr_o`, `write_data_o` = 0; `score_o`=0.
- Latency from the `start_i` cycle (cycle 0) to `done_o`: 1 + `size_p` + `cleared` + stall cycles. With default parameters and no stalls, 1 clear gives `done_o` at cycle 22.
- `read_addr_o` comes from registers. The write decision uses same-cycle `read_data_i`, so there is no read latency.
- `ready_o` falls in cycle 1 and rises the cycle after `done_o`.
- No write targets a row that has not yet been read, because `dst_r`≥`src_r` always.

## Configuration
- `LINE_CLEAR_SCORE_EN` defined:
  - `score_o` port and a 24-bit accumulator are present.
  - In eDONE, add 0/40/100/300/1200 for `cleared_r` = 0/1/2/3/≥4.
  - Saturate at 24'hFFFFFF.
  - Reset clears the accumulator; `start_i` does not.
- `LINE_CLEAR_SCORE_EN` undefined: no `score_o` port, no accumulator, otherwise identical.

## Test plan
- Reset with `reset_n_i`=0 for 2 cycles -> `ready_o`=1, `v_w_o`=0, `lines_cleared_o`=0, `score_o`=0.
- Rows 0..19 all 10'h001 (none full), start -> zero `v_w_o` pulses, `done_o` at cycle 21, `lines_cleared_o`=0, memory unchanged.
- Row 19=10'h3FF, row 18=10'h001, others 0, start -> row 19=10'h001, rows 0..18=0, `done_o` at cycle 22, `lines_cleared_o`=1, `score_o`=40.
- Rows 19,17=10'h3FF, row 18=10'h155, row 16=10'h2AA -> row 19=10'h155, row 18=10'h2AA, rows 0,1 zeroed, `lines_cleared_o`=2, `score_o`+=100.
- Same setup as the one-clear case, with `mem_ready_i`=0 for 3 cycles starting at cycle 5 -> no `v_w_o` during the stall, `done_o` at cycle 25, identical final memory.
- All 20 rows full -> 20 zero writes, `lines_cleared_o`=20, `score_o`+=1200. A separate run with `reset_n_i` pulled low at cycle 10 -> `ready_o`=1 next cycle and no further writes.

Source files
------------

// File: rtl/line_clear_engine.sv
// Post-lock line clear: scans the playfield bottom-up, drops full rows, compacts the rest downward, zero-fills the top.
// Latency: done_o 1 + size_p + cleared + stall cycles after the start_i cycle; read data is used in the same cycle.
// Backpressure: mem_ready_i=0 freezes eSCAN/eFILL (no pointer updates, no write strobe).
// Ports: clk_i/reset_n_i (sync, active-low); start_i/ready_o/done_o/lines_cleared_o to the game controller;
//        read_addr_o/read_data_i line read port; write_addr_o/write_data_o/v_w_o line write port; mem_ready_i.
// Optional: define LINE_CLEAR_SCORE_EN to add score_o, a saturating 24-bit score accumulator.
module line_clear_engine #(
    parameter int word_width_p = 10,
    parameter int size_p       = 20
) (
    input  logic                          clk_i,
    input  logic                          reset_n_i,
    input  logic                          start_i,
    output logic                          ready_o,
    output logic                          done_o,
    output logic [$clog2(size_p+1)-1:0]   lines_cleared_o,
    input  logic                          mem_ready_i,
    output logic [$clog2(size_p)-1:0]     read_addr_o,
    input  logic [word_width_p-1:0]       read_data_i,
    output logic [$clog2(size_p)-1:0]     write_addr_o,
    output logic [word_width_p-1:0]       write_data_o,
    output logic                          v_w_o
`ifdef LINE_CLEAR_SCORE_EN
    ,
    output logic [23:0]                   score_o
`endif
);
    localparam int AW = $clog2(size_p);
    localparam int CW = $clog2(size_p+1);
    localparam logic [AW-1:0] LAST_ROW = AW'(size_p-1);

    typedef enum logic [1:0] {eIDLE, eSCAN, eFILL, eDONE} state_e;

    state_e          state_q, state_d;
    logic [AW-1:0]   src_q, src_d;
    logic [AW-1:0]   dst_q, dst_d;
    logic [CW-1:0]   cleared_q, cleared_d;
    logic [CW-1:0]   lines_q, lines_d;
    logic            row_full;

    assign row_full        = &read_data_i;
    assign read_addr_o     = src_q;
    assign write_addr_o    = dst_q;
    assign lines_cleared_o = lines_q;

    always_comb begin
        state_d      = state_q;
        src_d        = src_q;
        dst_d        = dst_q;
        cleared_d    = cleared_q;
        lines_d      = lines_q;
        ready_o      = 1'b0;
        done_o       = 1'b0;
        v_w_o        = 1'b0;
        write_data_o = '0;
        case (state_q)
            eIDLE: begin
                ready_o = 1'b1;
                if (start_i) begin
                    src_d     = LAST_ROW;
                    dst_d     = LAST_ROW;
                    cleared_d = '0;
                    state_d   = eSCAN;
                end
            end
            eSCAN: begin
                if (mem_ready_i) begin
                    // Pointers saturate at row 0 so the addresses never leave the playfield.
                    if (row_full) begin
                        cleared_d = cleared_q + CW'(1);
                    end else begin
                        // src==dst means nothing below has been removed yet: row already in place.
                        if (src_q != dst_q) begin
                            v_w_o        = 1'b1;
                            write_data_o = read_data_i;
                        end
                        if (dst_q != '0) dst_d = dst_q - AW'(1);
                    end
                    if (src_q != '0) begin
                        src_d = src_q - AW'(1);
                    end else begin
                        state_d = (cleared_d != '0) ? eFILL : eDONE;
                    end
                end
            end
            eFILL: begin
                if (mem_ready_i) begin
                    v_w_o = 1'b1;
                    if (dst_q != '0) dst_d = dst_q - AW'(1);
                    else             state_d = eDONE;
                end
            end
            default: begin
                done_o  = 1'b1;
                lines_d = cleared_q;
                state_d = eIDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            state_q   <= eIDLE;
            src_q     <= '0;
            dst_q     <= '0;
            cleared_q <= '0;
            lines_q   <= '0;
        end else begin
            state_q   <= state_d;
            src_q     <= src_d;
            dst_q     <= dst_d;
            cleared_q <= cleared_d;
            lines_q   <= lines_d;
        end
    end

`ifdef LINE_CLEAR_SCORE_EN
    logic [23:0] score_q, score_d;
    logic [10:0] bonus;
    logic [24:0] score_sum;

    always_comb begin
        case (cleared_q)
            CW'(0):  bonus = 11'd0;
            CW'(1):  bonus = 11'd40;
            CW'(2):  bonus = 11'd100;
            CW'(3):  bonus = 11'd300;
            default: bonus = 11'd1200;
        endcase
        score_sum = {1'b0, score_q} + 25'(bonus);
        score_d   = score_q;
        if (state_q == eDONE) begin
            score_d = score_sum[24] ? 24'hFFFFFF : score_sum[23:0];
        end
    end

    // Accumulates across passes; only reset clears it.
    always_ff @(posedge clk_i) begin
        if (!reset_n_i) score_q <= '0;
        else            score_q <= score_d;
    end

    assign score_o = score_q;
`endif
endmodule

// File: tb/tb_line_clear_engine.sv
module tb_line_clear_engine;
    localparam int W    = 10;
    localparam int SIZE = 20;
    localparam int AW   = $clog2(SIZE);
    localparam int CW   = $clog2(SIZE+1);

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          start = 1'b0;
    logic          ready, done, v_w;
    logic [CW-1:0] lines_cleared;
    logic          mem_ready = 1'b1;
    logic [AW-1:0] read_addr, write_addr;
    logic [W-1:0]  read_data, write_data;
`ifdef LINE_CLEAR_SCORE_EN
    logic [23:0]   score;
`endif

    line_clear_engine #(.word_width_p(W), .size_p(SIZE)) dut (
        .clk_i(clk), .reset_n_i(reset_n), .start_i(start), .ready_o(ready), .done_o(done),
        .lines_cleared_o(lines_cleared), .mem_ready_i(mem_ready), .read_addr_o(read_addr),
        .read_data_i(read_data), .write_addr_o(write_addr), .write_data_o(write_data), .v_w_o(v_w)
`ifdef LINE_CLEAR_SCORE_EN
        , .score_o(score)
`endif
    );

    always #5 clk = ~clk;

    // Playfield memory: combinational read, write on the clock edge.
    logic [W-1:0] mem[SIZE];
    logic [W-1:0] load_img[SIZE];
    logic         load_req = 1'b0;
    assign read_data = mem[read_addr];
    always @(posedge clk) begin
        if (load_req)   mem <= load_img;
        else if (v_w)   mem[write_addr] <= write_data;
    end

    int total = 0;
    int passed = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    endtask

    // Reference model state
    logic [W-1:0]  img[SIZE];
    logic [W-1:0]  exp_mem[SIZE];
    logic [AW-1:0] wq_a[$];
    logic [W-1:0]  wq_d[$];
    int            exp_cleared;
    int            exp_done_k;
    longint        exp_score = 0;
    int            k = 0;
    bit            active = 1'b0;
    bit            seen_done;
    int            cur_rst_at = -1;
    bit            exp_ready;

    // Kept rows land at the bottom in original order, the top 'cleared' rows become zero.
    task automatic build_model();
        logic [W-1:0] kept[$];
        kept = {};
        wq_a = {};
        wq_d = {};
        exp_cleared = 0;
        for (int r = SIZE-1; r >= 0; r--) begin
            if (img[r] == {W{1'b1}}) exp_cleared++;
            else kept.push_back(img[r]);
        end
        for (int i = 0; i < SIZE; i++) begin
            int row;
            row = SIZE-1-i;
            if (i < kept.size()) begin
                exp_mem[row] = kept[i];
                if (img[row] !== kept[i] || exp_cleared > 0 && row != SIZE-1-i) begin end
            end else begin
                exp_mem[row] = '0;
            end
        end
        // Write sequence: every kept row that moved, bottom-up, then zero fills downward from the top survivor.
        begin
            int removed_below;
            removed_below = 0;
            for (int r = SIZE-1; r >= 0; r--) begin
                if (img[r] == {W{1'b1}}) removed_below++;
                else if (removed_below > 0) begin
                    wq_a.push_back(AW'(r + removed_below));
                    wq_d.push_back(img[r]);
                end
            end
            for (int r = exp_cleared-1; r >= 0; r--) begin
                wq_a.push_back(AW'(r));
                wq_d.push_back('0);
            end
        end
    endtask

    function automatic longint bonus(input int n);
        case (n)
            0: return 0;
            1: return 40;
            2: return 100;
            3: return 300;
            default: return 1200;
        endcase
    endfunction

    // Per-cycle comparison against the model while a pass is in flight.
    always @(negedge clk) begin
        if (active) begin
            exp_ready = (k == 0) || (cur_rst_at >= 0 && k > cur_rst_at);
            chk("ready_o", ready, exp_ready);
            chk("done_o", done, (cur_rst_at < 0) && (k == exp_done_k));
            if (done) seen_done = 1'b1;
            if (v_w) begin
                if (!mem_ready || (cur_rst_at >= 0 && k > cur_rst_at) || wq_a.size() == 0) begin
                    chk("stray_write", 1, 0);
                end else begin
                    chk("write_addr", write_addr, wq_a[0]);
                    chk("write_data", write_data, wq_d[0]);
                    void'(wq_a.pop_front());
                    void'(wq_d.pop_front());
                end
            end
            if (cur_rst_at < 0 && k == exp_done_k) chk("writes_outstanding", wq_a.size(), 0);
        end
    end

    task automatic run_pass(input int st0, input int stn, input int rst_at,
                            input int hand_done, input int hand_cleared);
        load_img = img;
        @(posedge clk); #1; load_req = 1'b1;
        @(posedge clk); #1; load_req = 1'b0;
        build_model();
        cur_rst_at = rst_at;
        exp_done_k = (rst_at >= 0) ? 100000 : 1 + SIZE + exp_cleared + stn;
        if (hand_done >= 0)    chk("model_done_cycle", exp_done_k, hand_done);
        if (hand_cleared >= 0) chk("model_cleared", exp_cleared, hand_cleared);
        seen_done = 1'b0;
        active = 1'b1;
        for (int c = 0; c < 200; c++) begin
            k = c;
            start = (c == 0);
            mem_ready = !(c >= st0 && c < st0 + stn);
            reset_n = (c != rst_at);
            @(posedge clk); #1;
            if (rst_at < 0 && c == exp_done_k) break;
            if (rst_at >= 0 && c == rst_at + 25) break;
        end
        active = 1'b0;
        start = 1'b0;
        mem_ready = 1'b1;
        reset_n = 1'b1;
        chk("done_seen", seen_done, rst_at < 0);
        @(negedge clk);
        chk("ready_after", ready, 1);
        if (rst_at < 0) begin
            exp_score = exp_score + bonus(exp_cleared);
            if (exp_score > 64'hFFFFFF) exp_score = 64'hFFFFFF;
            chk("lines_cleared_o", lines_cleared, exp_cleared);
            for (int r = 0; r < SIZE; r++) if (mem[r] !== exp_mem[r]) chk($sformatf("mem[%0d]", r), mem[r], exp_mem[r]);
            chk("mem_all_rows", 1, 1 == 1 ? (mem == exp_mem) : 0);
        end else begin
            exp_score = 0;
            chk("lines_cleared_after_reset", lines_cleared, 0);
            chk("mem_unchanged_after_reset", mem == img, 1);
        end
`ifdef LINE_CLEAR_SCORE_EN
        chk("score_o", score, exp_score);
`endif
    endtask

    initial begin
        reset_n = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        @(negedge clk);
        chk("rst_ready", ready, 1);
        chk("rst_done", done, 0);
        chk("rst_v_w", v_w, 0);
        chk("rst_lines", lines_cleared, 0);
        chk("rst_read_addr", read_addr, 0);
        chk("rst_write_addr", write_addr, 0);
        chk("rst_write_data", write_data, 0);
`ifdef LINE_CLEAR_SCORE_EN
        chk("rst_score", score, 0);
`endif
        @(posedge clk); #1;
        reset_n = 1'b1;

        // No full rows
        for (int r = 0; r < SIZE; r++) img[r] = 10'h001;
        run_pass(-1, 0, -1, 21, 0);
        chk("none_row0", mem[0], 10'h001);
        chk("none_row19", mem[19], 10'h001);

        // One clear
        for (int r = 0; r < SIZE; r++) img[r] = '0;
        img[19] = 10'h3FF; img[18] = 10'h001;
        run_pass(-1, 0, -1, 22, 1);
        chk("one_row19", mem[19], 10'h001);
        chk("one_row18", mem[18], 10'h000);
`ifdef LINE_CLEAR_SCORE_EN
        chk("one_score_lit", score, 40);
`endif

        // Two clears, interleaved
        for (int r = 0; r < SIZE; r++) img[r] = '0;
        img[19] = 10'h3FF; img[18] = 10'h155; img[17] = 10'h3FF; img[16] = 10'h2AA;
        img[0] = 10'h0F0; img[1] = 10'h00F;
        run_pass(-1, 0, -1, 23, 2);
        chk("two_row19", mem[19], 10'h155);
        chk("two_row18", mem[18], 10'h2AA);
        chk("two_row2", mem[2], 10'h0F0);
        chk("two_row3", mem[3], 10'h00F);
        chk("two_row1", mem[1], 10'h000);
        chk("two_row0", mem[0], 10'h000);

        // One clear with a 3-cycle stall from cycle 5
        for (int r = 0; r < SIZE; r++) img[r] = '0;
        img[19] = 10'h3FF; img[18] = 10'h001;
        run_pass(5, 3, -1, 25, 1);
        chk("stall_row19", mem[19], 10'h001);

        // All rows full
        for (int r = 0; r < SIZE; r++) img[r] = 10'h3FF;
        run_pass(-1, 0, -1, 41, 20);
        chk("full_row0", mem[0], 10'h000);
        chk("full_row19", mem[19], 10'h000);

        // Randomized playfields with random stall windows inside the scan
        for (int t = 0; t < 12; t++) begin
            int st0, stn;
            for (int r = 0; r < SIZE; r++)
                img[r] = ($urandom_range(0, 2) == 0) ? 10'h3FF : W'($urandom);
            st0 = int'($urandom_range(1, SIZE-4));
            stn = int'($urandom_range(0, 4));
            run_pass(st0, stn, -1, -1, -1);
        end

        // All full, reset pulled at cycle 10
        for (int r = 0; r < SIZE; r++) img[r] = 10'h3FF;
        run_pass(-1, 0, 10, -1, 20);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
